// File: rtl/text_buf_writer.sv
// text_buf_writer: write side of the text-mode screen buffer.
// Takes a byte stream of ASCII characters and control codes. It tracks
// the cursor and writes printable codes into the screen RAM. It also
// clears lines and the whole screen, so the RAM only ever holds codes
// that the character ROM can render.
module text_buf_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  CLEAR_CHR = 8'h20,
  // Derived widths of the cursor outputs; not meant to be overridden.
  parameter int          COL_W     = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int          ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);

  // Control codes handled by the writer; every other non-printable is dropped.
  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  // Last counter value of each clear sweep.
  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCREEN
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_n;
  logic [COL_W-1:0]    col_n;
  logic [ROW_W-1:0]    row_n;
  logic                wr_en_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [7:0]          wr_data_n;

  logic                accept;
  logic                printable;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ROW_W-1:0]    next_row;

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign accept    = in_valid && in_ready;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  // The row base is formed at full address width so row*COLS never truncates.
  assign row_base  = ADDR_W'(cur_row) * ADDR_W'(COLS);
  assign cur_addr  = row_base + ADDR_W'(cur_col);

  // The bottom row wraps to row 0; that row is cleared and reused, not scrolled.
  assign next_row  = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (!rst_n) state <= CLR_SCREEN;
    else        state <= state_n;
  end

  // Cursor, clear counter and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_col <= '0;
      cur_row <= '0;
      clr_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      cur_col <= col_n;
      cur_row <= row_n;
      clr_cnt <= clr_cnt_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Next-state, cursor update and the write for the coming edge.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    state_n   = state;
    col_n     = cur_col;
    row_n     = cur_row;
    clr_cnt_n = clr_cnt;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            wr_en_n   = 1'b1;
            wr_addr_n = cur_addr;
            wr_data_n = in_data;
            if (cur_col == COL_LAST) begin
              // Line wrap behaves like an implicit newline.
              col_n     = '0;
              row_n     = next_row;
              clr_cnt_n = '0;
              state_n   = CLR_LINE;
            end else begin
              col_n = cur_col + 1'b1;
            end
          end else begin
            unique case (in_data)
              CHR_CR: col_n = '0;
              CHR_LF: begin
                col_n     = '0;
                row_n     = next_row;
                clr_cnt_n = '0;
                state_n   = CLR_LINE;
              end
              CHR_BS: begin
                // Backspace stops at column 0; it never wraps to the row above.
                if (cur_col != '0) begin
                  col_n     = cur_col - 1'b1;
                  wr_en_n   = 1'b1;
                  wr_addr_n = cur_addr - 1'b1;
                  wr_data_n = CLEAR_CHR;
                end
              end
              CHR_FF: begin
                col_n     = '0;
                row_n     = '0;
                clr_cnt_n = '0;
                state_n   = CLR_SCREEN;
              end
              default: ;  // other control codes are swallowed
            endcase
          end
        end
      end

      CLR_LINE: begin
        // cur_row already points at the new row, so it sets the sweep base.
        wr_en_n   = 1'b1;
        wr_addr_n = row_base + clr_cnt;
        wr_data_n = CLEAR_CHR;
        if (clr_cnt == LINE_LAST) begin
          clr_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end

      CLR_SCREEN: begin
        wr_en_n   = 1'b1;
        wr_addr_n = clr_cnt;
        wr_data_n = CLEAR_CHR;
        if (clr_cnt == SCREEN_LAST) begin
          clr_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
